// File: rtl/gray_counter_4b_if.sv
// Control/data bundle for the Gray counter.
// master drives en/up/load/load_val; slave returns g/valid/wrap.
interface gray_counter_4b_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] g;
    logic             valid;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  g, valid, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output g, valid, wrap
    );
endinterface

// File: rtl/gray_counter_4b.sv
// Up/down Gray counter with Gray-coded synchronous load.
// Ports: clk, rst (async high), bus (slave: en/up/load/load_val in, g/valid/wrap out).
module gray_counter_4b #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    gray_counter_4b_if.slave  bus
);
    localparam logic [WIDTH-1:0] BIN_MAX = '1;
    localparam logic [WIDTH-1:0] BIN_MIN = '0;

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] g_q;
    logic             valid_q;
    logic             wrap_q;

    logic [WIDTH-1:0] bin_ld;
    logic [WIDTH-1:0] bin_nx;
    logic             valid_nx;
    logic             wrap_nx;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin_ld = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_ld[i] = ^(bus.load_val >> i);
        end
    end

    // The count is kept in binary so stepping is a plain add/subtract;
    // the Gray image of the next value is registered for g.
    always_comb begin
        bin_nx   = bin_q;
        valid_nx = 1'b0;
        wrap_nx  = 1'b0;
        if (bus.load) begin
            bin_nx   = bin_ld;
            valid_nx = 1'b1;
        end else if (bus.en) begin
            valid_nx = 1'b1;
            if (bus.up) begin
                bin_nx  = bin_q + 1'b1;
                wrap_nx = (bin_q == BIN_MAX);
            end else begin
                bin_nx  = bin_q - 1'b1;
                wrap_nx = (bin_q == BIN_MIN);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q   <= '0;
            g_q     <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            bin_q   <= bin_nx;
            g_q     <= bin_nx ^ (bin_nx >> 1);
            valid_q <= valid_nx;
            wrap_q  <= wrap_nx;
        end
    end

    assign bus.g     = g_q;
    assign bus.valid = valid_q;
    assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_gray_counter_4b.sv
// Scoreboard bench for gray_counter_4b (WIDTH=4).
// Driver pushes model expectations; a monitor pops and compares each cycle.
module tb_gray_counter_4b;
    localparam int W = 4;
    localparam int N = 1 << W;

    typedef struct {
        logic [W-1:0] g;
        logic         v;
        logic         w;
        logic         ld;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    gray_counter_4b_if #(.WIDTH(W)) bus ();

    gray_counter_4b #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t         q[$];
    int           errs   = 0;
    int           checks = 0;
    int           pos    = 0;
    logic [W-1:0] prev_g = '0;

    function automatic logic [W-1:0] gray_of(input int n);
        int t;
        t = n ^ (n >> 1);
        return t[W-1:0];
    endfunction

    // Position of a code in the sequence, found by searching the sequence.
    function automatic int idx_of(input logic [W-1:0] v);
        for (int n = 0; n < N; n++) begin
            if (gray_of(n) == v) return n;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, req, $time);
        end
    endtask

    task automatic push_exp(input logic v, input logic w, input logic ld);
        exp_t e;
        e.g  = gray_of(pos);
        e.v  = v;
        e.w  = w;
        e.ld = ld;
        q.push_back(e);
    endtask

    task automatic step(input logic e, input logic u, input logic l,
                        input logic [W-1:0] lv);
        logic w;
        @(negedge clk);
        bus.en       = e;
        bus.up       = u;
        bus.load     = l;
        bus.load_val = lv;
        w = 1'b0;
        if (l) begin
            pos = idx_of(lv);
        end else if (e && u) begin
            w   = (pos == N - 1);
            pos = (pos + 1) % N;
        end else if (e) begin
            w   = (pos == 0);
            pos = (pos + N - 1) % N;
        end
        push_exp(l | e, w, l);
    endtask

    task automatic check_reset_outs(input string name);
        chk({name, "_g"}, 32'(bus.g), 32'd0);
        chk({name, "_valid"}, 32'(bus.valid), 32'd0);
        chk({name, "_wrap"}, 32'(bus.wrap), 32'd0);
    endtask

    // Reset pulsed between edges, with busy inputs while it is high.
    task automatic pulse_reset();
        @(negedge clk);
        bus.en       = 1'b1;
        bus.up       = 1'($urandom);
        bus.load     = 1'($urandom);
        bus.load_val = W'($urandom);
        #2 rst = 1'b1;
        #1 check_reset_outs("pulse_rst");
        bus.en   = 1'b0;
        bus.load = 1'b0;
        #1 rst = 1'b0;
        pos = 0;
        push_exp(1'b0, 1'b0, 1'b0);
    endtask

    // Reset held across a rising edge; inputs during it must be ignored.
    task automatic long_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.up       = 1'b1;
        bus.load     = 1'b1;
        bus.load_val = 4'b1011;
        #1 check_reset_outs("long_rst_now");
        @(posedge clk);
        #2 check_reset_outs("long_rst_edge");
        @(negedge clk);
        rst      = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        pos = 0;
        push_exp(1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (q.size() == 0) begin
                    chk("queue_underflow", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    chk("g", 32'(bus.g), 32'(e.g));
                    chk("valid", 32'(bus.valid), 32'(e.v));
                    chk("wrap", 32'(bus.wrap), 32'(e.w));
                    if (e.v && !e.ld) begin
                        chk("one_bit_change",
                            32'($countones(bus.g ^ prev_g)), 32'd1);
                    end
                    prev_g = bus.g;
                end
            end
        end
    end

    initial begin : driver
        rst          = 1'b1;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;
        #1 check_reset_outs("init_rst");
        long_reset();

        // Full up cycle, ends at 0000 with wrap on the last step.
        for (int i = 0; i < N; i++) step(1'b1, 1'b1, 1'b0, '0);

        // Down wrap from reset.
        pulse_reset();
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);

        // Load beats enable, then count on from the loaded code.
        step(1'b1, 1'b0, 1'b1, 4'b1100);
        step(1'b1, 1'b1, 1'b0, '0);

        // Hold.
        step(1'b0, 1'b1, 1'b1, 4'b0110);
        for (int i = 0; i < 5; i++) step(1'b0, 1'($urandom), 1'b0, W'($urandom));

        // Async reset mid-count.
        step(1'b0, 1'b1, 1'b1, 4'b1010);
        pulse_reset();
        step(1'b1, 1'b1, 1'b0, '0);

        // Direction change.
        pulse_reset();
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, '0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 1'($urandom),
                     $urandom_range(0, 7) == 0, W'($urandom));
            end
        end

        step(1'b0, 1'b0, 1'b0, '0);
        @(posedge clk);
        #3 chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/gray_counter_4b.md
GRAY_COUNTER_4B -- requirements
Module: gray_counter_4b

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; the block SHALL support 2..16.
REQ-002 Port clk  input  1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1: asynchronous, active-high reset.
REQ-004 Port en  input  1: count enable; one Gray step per cycle while high.
REQ-005 Port up  input  1: direction; 1 = increment, 0 = decrement.
REQ-006 Port load  input  1: synchronous load strobe.
REQ-007 Port load_val  input  WIDTH: Gray-coded value to load.
REQ-008 Port g  output  WIDTH: registered Gray count; feeds the downstream Gray-to-binary stage.
REQ-009 Port valid  output  1: one-cycle strobe, high in the cycle after g was updated.
REQ-010 Port wrap  output  1: one-cycle strobe, high in the cycle after a step crossed the end of the sequence.

Function
REQ-011 The block SHALL hold an internal count and present it only in Gray code on g.
- g SHALL come directly from a flop.
- g SHALL have no combinational path from any input.
REQ-012 Sequence for WIDTH=4, up direction:
- 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then back to 0000.
REQ-013 Each enabled step SHALL change exactly one bit of g, including the wrap step.
REQ-014 Priority per cycle SHALL be load > en > hold.
REQ-015 load=1 SHALL set g=load_val on the next edge, regardless of en and up.
- A load SHALL assert valid.
- A load SHALL NOT assert wrap.
REQ-016 load=0 and en=1 SHALL step g one position in the sequence, in the direction given by up.
- The next cycle SHALL have valid=1.
REQ-017 load=0 and en=0 SHALL hold g.
- The next cycle SHALL have valid=0 and wrap=0.
REQ-018 An up step from the last code (1000 at WIDTH=4) SHALL produce g=0000.
- wrap SHALL be 1 in that cycle.
REQ-019 A down step from 0000 SHALL produce the last code (1000 at WIDTH=4).
- wrap SHALL be 1 in that cycle.
REQ-020 Changing up between cycles SHALL take effect on the very next step, with no lost or extra step.
REQ-021 valid and wrap SHALL each be high for exactly one cycle per qualifying event.
- Continuous en SHALL give continuous valid.
REQ-022 Latency from a sampled input to the g/valid/wrap update SHALL be one clock.
REQ-023 load_val SHALL be treated as a Gray value.
- Loading any WIDTH-bit pattern SHALL be legal.
- Counting SHALL continue from the loaded value's position in the sequence.

Reset
REQ-024 While rst=1, the outputs SHALL be g=0, valid=0, wrap=0.
- The outputs SHALL take these values immediately, without waiting for clk.
REQ-025 Reset asserted mid-count SHALL abort the step in progress.
REQ-026 After rst is deasserted, the first enabled edge SHALL produce g=0001 when up=1, or g=1000 when up=0.
REQ-027 Inputs sampled while rst=1 SHALL have no effect.

Verification
REQ-028 Full up cycle:
- Stimulus: reset, then en=1, up=1 for 16 cycles.
- Response: g walks the REQ-012 list and ends at 0000; wrap=1 only on the final cycle; valid=1 on all 16 cycles.
- Also check the one-bit-change property of REQ-013 on every step.
REQ-029 Down wrap:
- Stimulus: reset, then en=1, up=0 for 1 cycle.
- Response: g=1000, wrap=1; the next down step gives g=1001, wrap=0.
REQ-030 Load priority:
- Stimulus: load=1, load_val=1100, en=1.
- Response: g=1100, valid=1, wrap=0; the next up step gives g=1101.
REQ-031 Hold:
- Stimulus: from g=0110, hold en=0 for 5 cycles.
- Response: g stays 0110; valid=0 and wrap=0 throughout.
REQ-032 Async reset mid-count:
- Stimulus: from g=1010, pulse rst between clock edges.
- Response: g=0000 and valid=0 before the next edge; after release, en=1, up=1 gives g=0001.
REQ-033 Direction change:
- Stimulus: up steps to 0011, then toggle up=0 for one step.
- Response: g=0001 with no lost or extra step.
